fwd_hazard_unit: RTL and testbench

//  Produces ForwardA/ForwardB selects for the EX-stage operand muxes and the load-use stall for the 16-bit pipeline.

---
 rtl/fwd_hazard_unit_pkg.sv | 24 ++
 rtl/fwd_hazard_unit_fwd_select.sv | 45 ++++
 rtl/fwd_hazard_unit.sv | 142 ++++++++++++++
 tb/tb_fwd_hazard_unit.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/fwd_hazard_unit_pkg.sv
// Shared pipeline definitions for the forwarding / hazard unit.
//  - PIPE_RADDR_W : default register-address width (16 architectural regs)
//  - fwd_sel_e    : EX operand-mux select encodings
//  - stage_rec_t  : destination/source record carried per pipeline stage
package pipe_pkg;

  localparam int unsigned PIPE_RADDR_W = 4;

  typedef enum logic [1:0] {
    FWD_IDEX  = 2'b00,  // operand from ID/EX register file read
    FWD_MEMWB = 2'b01,  // operand from MEM/WB result
    FWD_EXMEM = 2'b10   // operand from EX/MEM ALU result
  } fwd_sel_e;

  typedef struct packed {
    logic                    valid;
    logic [PIPE_RADDR_W-1:0] rs;
    logic [PIPE_RADDR_W-1:0] rt;
    logic [PIPE_RADDR_W-1:0] rd;
    logic                    regwrite;
    logic                    memread;
  } stage_rec_t;

endpackage

// File: rtl/fwd_hazard_unit_fwd_select.sv
// Operand-forward select for one EX source register.
// Ports:
//  i_ex_valid     EX holds a real instruction
//  i_src          EX source register address
//  i_mem_writer   MEM stage writes a non-zero register
//  i_mem_memread  MEM stage is a load (its data is not ready yet)
//  i_mem_rd       MEM destination register
//  i_wb_writer    WB stage writes a non-zero register
//  i_wb_rd        WB destination register
//  o_sel          2-bit mux select (FWD_* encodings)
module fwd_select
  import pipe_pkg::*;
#(
  parameter int unsigned RADDR_W = PIPE_RADDR_W
) (
  input  logic               i_ex_valid,
  input  logic [RADDR_W-1:0] i_src,
  input  logic               i_mem_writer,
  input  logic               i_mem_memread,
  input  logic [RADDR_W-1:0] i_mem_rd,
  input  logic               i_wb_writer,
  input  logic [RADDR_W-1:0] i_wb_rd,
  output logic [1:0]         o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;

  // Writer flags already exclude rd==0, so r0 can never be forwarded.
  // A load in MEM has no data to offer; fall through to WB instead.
  assign w_mem_hit = i_mem_writer & ~i_mem_memread & (i_mem_rd == i_src);
  assign w_wb_hit  = i_wb_writer & (i_wb_rd == i_src);

  always_comb begin
    o_sel = FWD_IDEX;
    if (i_ex_valid) begin
      if (w_mem_hit) begin
        o_sel = FWD_EXMEM;
      end else if (w_wb_hit) begin
        o_sel = FWD_MEMWB;
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard unit for the 16-bit pipeline.
// Shadows EX/MEM/WB destination info in lockstep with the pipeline
// registers and produces operand-forward selects plus the load-use stall.
// Ports:
//  clk, rst       rising-edge clock, synchronous active-high reset
//  id_*           decoded fields of the instruction currently in ID
//  flush          taken branch: squash the instruction in ID
//  ForwardA/B     EX operand-mux selects
//  stall          hold PC and IF/ID, bubble ID/EX
//  hazard_err     EX consumer matches a load in MEM (should never happen)
//  stall_count    saturating count of stall cycles since reset
module fwd_hazard_unit
  import pipe_pkg::*;
#(
  parameter int unsigned RADDR_W = PIPE_RADDR_W,
  parameter int unsigned CNT_W   = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic [RADDR_W-1:0] id_rs,
  input  logic [RADDR_W-1:0] id_rt,
  input  logic [RADDR_W-1:0] id_rd,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               id_uses_rt,
  input  logic               flush,
  output logic [1:0]         ForwardA,
  output logic [1:0]         ForwardB,
  output logic               stall,
  output logic               hazard_err,
  output logic [CNT_W-1:0]   stall_count
);

  // EX record keeps sources; MEM/WB only need destination info.
  logic               r_ex_valid;
  logic [RADDR_W-1:0] r_ex_rs;
  logic [RADDR_W-1:0] r_ex_rt;
  logic [RADDR_W-1:0] r_ex_rd;
  logic               r_ex_regwrite;
  logic               r_ex_memread;

  logic               r_mem_valid;
  logic [RADDR_W-1:0] r_mem_rd;
  logic               r_mem_regwrite;
  logic               r_mem_memread;

  logic               r_wb_valid;
  logic [RADDR_W-1:0] r_wb_rd;
  logic               r_wb_regwrite;

  logic [CNT_W-1:0]   r_stall_count;

  logic w_ex_writer;
  logic w_mem_writer;
  logic w_wb_writer;
  logic w_stall;

  assign w_ex_writer  = r_ex_valid  & r_ex_regwrite  & (r_ex_rd  != '0);
  assign w_mem_writer = r_mem_valid & r_mem_regwrite & (r_mem_rd != '0);
  assign w_wb_writer  = r_wb_valid  & r_wb_regwrite  & (r_wb_rd  != '0);

  assign w_stall = id_valid & w_ex_writer & r_ex_memread &
                   ((r_ex_rd == id_rs) | (id_uses_rt & (r_ex_rd == id_rt)));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ex_valid     <= 1'b0;
      r_ex_rs        <= '0;
      r_ex_rt        <= '0;
      r_ex_rd        <= '0;
      r_ex_regwrite  <= 1'b0;
      r_ex_memread   <= 1'b0;
      r_mem_valid    <= 1'b0;
      r_mem_rd       <= '0;
      r_mem_regwrite <= 1'b0;
      r_mem_memread  <= 1'b0;
      r_wb_valid     <= 1'b0;
      r_wb_rd        <= '0;
      r_wb_regwrite  <= 1'b0;
      r_stall_count  <= '0;
    end else begin
      r_wb_valid     <= r_mem_valid;
      r_wb_rd        <= r_mem_rd;
      r_wb_regwrite  <= r_mem_regwrite;

      r_mem_valid    <= r_ex_valid;
      r_mem_rd       <= r_ex_rd;
      r_mem_regwrite <= r_ex_regwrite;
      r_mem_memread  <= r_ex_memread;

      // Flush outranks stall: a squashed ID must not also be counted as a bubble.
      if (flush || w_stall) begin
        r_ex_valid    <= 1'b0;
        r_ex_rs       <= '0;
        r_ex_rt       <= '0;
        r_ex_rd       <= '0;
        r_ex_regwrite <= 1'b0;
        r_ex_memread  <= 1'b0;
      end else begin
        r_ex_valid    <= id_valid;
        r_ex_rs       <= id_rs;
        r_ex_rt       <= id_rt;
        r_ex_rd       <= id_rd;
        r_ex_regwrite <= id_regwrite;
        r_ex_memread  <= id_memread;
      end

      if (w_stall && !flush && (r_stall_count != '1)) begin
        r_stall_count <= r_stall_count + 1'b1;
      end
    end
  end

  fwd_select #(.RADDR_W(RADDR_W)) u_fwd_a (
    .i_ex_valid    (r_ex_valid),
    .i_src         (r_ex_rs),
    .i_mem_writer  (w_mem_writer),
    .i_mem_memread (r_mem_memread),
    .i_mem_rd      (r_mem_rd),
    .i_wb_writer   (w_wb_writer),
    .i_wb_rd       (r_wb_rd),
    .o_sel         (ForwardA)
  );

  fwd_select #(.RADDR_W(RADDR_W)) u_fwd_b (
    .i_ex_valid    (r_ex_valid),
    .i_src         (r_ex_rt),
    .i_mem_writer  (w_mem_writer),
    .i_mem_memread (r_mem_memread),
    .i_mem_rd      (r_mem_rd),
    .i_wb_writer   (w_wb_writer),
    .i_wb_rd       (r_wb_rd),
    .o_sel         (ForwardB)
  );

  assign stall       = w_stall;
  assign hazard_err  = r_ex_valid & w_mem_writer & r_mem_memread &
                       ((r_mem_rd == r_ex_rs) | (r_mem_rd == r_ex_rt));
  assign stall_count = r_stall_count;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit. Counter narrowed to 3 bits so the
// saturation boundary is reachable in a short run.
module tb_fwd_hazard_unit;

  localparam int unsigned RW = 4;
  localparam int unsigned CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          id_valid;
  logic [RW-1:0] id_rs;
  logic [RW-1:0] id_rt;
  logic [RW-1:0] id_rd;
  logic          id_regwrite;
  logic          id_memread;
  logic          id_uses_rt;
  logic          flush;
  logic [1:0]    ForwardA;
  logic [1:0]    ForwardB;
  logic          stall;
  logic          hazard_err;
  logic [CW-1:0] stall_count;

  int n_assert = 0;
  int n_fail   = 0;

  fwd_hazard_unit #(.RADDR_W(RW), .CNT_W(CW)) dut (
    .clk         (clk),
    .rst         (rst),
    .id_valid    (id_valid),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_uses_rt  (id_uses_rt),
    .flush       (flush),
    .ForwardA    (ForwardA),
    .ForwardB    (ForwardB),
    .stall       (stall),
    .hazard_err  (hazard_err),
    .stall_count (stall_count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [RW-1:0] rs, input logic [RW-1:0] rt,
                       input logic [RW-1:0] rd, input logic rw, input logic mr,
                       input logic urt);
    id_valid    = v;
    id_rs       = rs;
    id_rt       = rt;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_uses_rt  = urt;
    flush       = 1'b0;
  endtask

  task automatic nop();
    drive(1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic chk(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                     input logic st, input logic he, input logic [CW-1:0] cnt);
    @(negedge clk);
    n_assert++;
    assert (ForwardA === fa) else begin
      n_fail++;
      $error("FAIL %s ForwardA observed=%b expected=%b", tag, ForwardA, fa);
    end
    n_assert++;
    assert (ForwardB === fb) else begin
      n_fail++;
      $error("FAIL %s ForwardB observed=%b expected=%b", tag, ForwardB, fb);
    end
    n_assert++;
    assert (stall === st) else begin
      n_fail++;
      $error("FAIL %s stall observed=%b expected=%b", tag, stall, st);
    end
    n_assert++;
    assert (hazard_err === he) else begin
      n_fail++;
      $error("FAIL %s hazard_err observed=%b expected=%b", tag, hazard_err, he);
    end
    n_assert++;
    assert (stall_count === cnt) else begin
      n_fail++;
      $error("FAIL %s stall_count observed=%0d expected=%0d", tag, stall_count, cnt);
    end
  endtask

  initial begin
    rst = 1'b1;
    nop();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0);
    cyc();

    // add r1 then a reader of r1: EX/MEM forward on A
    drive(1, 4, 5, 1, 1, 0, 1); cyc();
    drive(1, 1, 6, 7, 1, 0, 1); chk("t1_id", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0); cyc();
    nop();                      chk("t1_fwd", 2'b10, 2'b00, 1'b0, 1'b0, 3'd0); cyc();
    chk("t1_bubble", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0); cyc();

    // add r2; nop; sub rt=r2 -> WB forward; then MEM beats WB for r2
    drive(1, 8, 9, 2, 1, 0, 1);    cyc();
    nop();                         cyc();
    drive(1, 10, 2, 11, 1, 0, 1);  chk("t2_id", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0); cyc();
    drive(1, 12, 13, 2, 1, 0, 1);  chk("t2_wb", 2'b00, 2'b01, 1'b0, 1'b0, 3'd0); cyc();
    drive(1, 12, 13, 2, 1, 0, 1);  cyc();
    drive(1, 2, 2, 11, 1, 0, 1);   cyc();
    nop();                         chk("t2_mem", 2'b10, 2'b10, 1'b0, 1'b0, 3'd0); cyc();
    nop();                         cyc();
    nop();                         cyc();

    // lw r3; add rs=r3 -> one stall, then WB forward
    drive(1, 4, 0, 3, 1, 1, 0);    chk("t3_lw", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0); cyc();
    drive(1, 3, 5, 6, 1, 0, 1);    chk("t3_stall", 2'b00, 2'b00, 1'b1, 1'b0, 3'd0); cyc();
    chk("t3_held", 2'b00, 2'b00, 1'b0, 1'b0, 3'd1); cyc();
    nop();                         chk("t3_fwd", 2'b01, 2'b00, 1'b0, 1'b0, 3'd1); cyc();

    // load-use coinciding with flush: not counted, EX squashed
    drive(1, 4, 0, 3, 1, 1, 0);    cyc();
    drive(1, 3, 5, 6, 1, 0, 1);
    flush = 1'b1;                  chk("t4_stall", 2'b00, 2'b00, 1'b1, 1'b0, 3'd1); cyc();
    nop();                         chk("t4_flush", 2'b00, 2'b00, 1'b0, 1'b0, 3'd1); cyc();

    // immediate form reading rt=r3 behind a load: no stall, hazard_err, WB fallback
    drive(1, 4, 5, 3, 1, 0, 1);    cyc();
    drive(1, 6, 0, 3, 1, 1, 0);    cyc();
    drive(1, 4, 3, 7, 1, 0, 0);    chk("th_id", 2'b00, 2'b00, 1'b0, 1'b0, 3'd1); cyc();
    nop();                         chk("th_err", 2'b00, 2'b01, 1'b0, 1'b1, 3'd1); cyc();

    // r0 is never forwarded and never causes a stall
    drive(1, 1, 1, 0, 1, 0, 1);    cyc();
    drive(1, 0, 0, 5, 1, 0, 1);    chk("t0_id", 2'b00, 2'b00, 1'b0, 1'b0, 3'd1); cyc();
    drive(1, 0, 0, 5, 1, 0, 1);    chk("t0_mem", 2'b00, 2'b00, 1'b0, 1'b0, 3'd1); cyc();
    drive(1, 1, 0, 0, 1, 1, 0);    chk("t0_wb", 2'b00, 2'b00, 1'b0, 1'b0, 3'd1); cyc();
    drive(1, 0, 0, 5, 1, 0, 1);    chk("t0_lw", 2'b00, 2'b00, 1'b0, 1'b0, 3'd1); cyc();
    nop();                         cyc();
    nop();                         cyc();

    // back-to-back loads to r3, each dependent: two separate stalls
    drive(1, 4, 0, 3, 1, 1, 0);    cyc();
    drive(1, 3, 0, 3, 1, 1, 0);    chk("bb_stall1", 2'b00, 2'b00, 1'b1, 1'b0, 3'd1); cyc();
    chk("bb_held1", 2'b00, 2'b00, 1'b0, 1'b0, 3'd2); cyc();
    drive(1, 3, 5, 6, 1, 0, 1);    chk("bb_stall2", 2'b01, 2'b00, 1'b1, 1'b0, 3'd2); cyc();
    chk("bb_held2", 2'b00, 2'b00, 1'b0, 1'b0, 3'd3); cyc();
    nop();                         chk("bb_fwd", 2'b01, 2'b00, 1'b0, 1'b0, 3'd3); cyc();

    // six more stalls: 3 + 6 saturates at 7
    for (int i = 0; i < 6; i++) begin
      drive(1, 4, 0, 3, 1, 1, 0);  cyc();
      drive(1, 3, 5, 6, 1, 0, 1);  cyc();
      cyc();
      nop();                       cyc();
    end
    chk("sat", 2'b00, 2'b00, 1'b0, 1'b0, 3'd7); cyc();

    // reset with writers in EX/MEM/WB and a pending stall
    drive(1, 4, 5, 1, 1, 0, 1);    cyc();
    drive(1, 4, 5, 2, 1, 0, 1);    cyc();
    drive(1, 4, 0, 3, 1, 1, 0);    cyc();
    drive(1, 3, 2, 6, 1, 0, 1);
    rst = 1'b1;                    chk("rst_pre", 2'b00, 2'b00, 1'b1, 1'b0, 3'd7); cyc();
    rst = 1'b0;
    drive(1, 1, 2, 6, 1, 0, 1);    chk("rst_post", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0); cyc();
    nop();                         chk("rst_ex", 2'b00, 2'b00, 1'b0, 1'b0, 3'd0); cyc();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout n_fail=%0d required=completion", n_fail);
    $fatal(1, "timeout");
  end

endmodule
